// File: rtl/linear_layer_srl_fifo_if.sv
// Stream FIFO handshake bundle: write side, read side, status flags and occupancy.
// Payload and counter widths follow the FIFO parameters.
interface linear_layer_srl_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_almost_full_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output if_write_ce, if_write, if_din, if_read_ce, if_read,
    input  if_full_n, if_almost_full_n, if_dout, if_empty_n, count
  );

  modport slave (
    input  if_write_ce, if_write, if_din, if_read_ce, if_read,
    output if_full_n, if_almost_full_n, if_dout, if_empty_n, count
  );
endinterface

// File: rtl/linear_layer_srl_fifo.sv
// SRL-based stream FIFO with registered flags, occupancy count and an optional
// registered first-word-fall-through output stage (OUT_REG=1).
module linear_layer_srl_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int OUT_REG    = 1,
  parameter int AF_MARGIN  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  linear_layer_srl_fifo_if.slave fifo
);
  localparam int CW        = ADDR_WIDTH + 1;
  localparam int CAPACITY  = DEPTH + OUT_REG;
  localparam int AF_TH     = CAPACITY - AF_MARGIN;
  localparam bit AF_ALWAYS = (AF_TH <= 0);
  localparam logic [CW-1:0] CAP_C   = CW'(CAPACITY);
  localparam logic [CW-1:0] AF_TH_C = AF_ALWAYS ? '0 : CW'(AF_TH);

  logic [DATA_WIDTH-1:0] r_srl [DEPTH];
  logic [CW-1:0]         r_srl_cnt;
  logic [CW-1:0]         r_count;
  logic                  r_full_n;
  logic                  r_empty_n;
  logic                  r_af_n;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_srl_pop;
  logic                  w_ov;
  logic                  w_ov_next;
  logic [CW-1:0]         w_srl_cnt_next;
  logic [CW-1:0]         w_cnt_next;
  logic [ADDR_WIDTH-1:0] w_head_idx;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_wr_acc   = fifo.if_write & fifo.if_write_ce & r_full_n & ~reset;
  assign w_rd_acc   = fifo.if_read & fifo.if_read_ce & r_empty_n & ~reset;
  assign w_head_idx = ADDR_WIDTH'(r_srl_cnt - 1'b1);
  assign w_head     = r_srl[w_head_idx];

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_srl[0] <= fifo.if_din;
      for (int unsigned i = 1; i < unsigned'(DEPTH); i++) begin
        r_srl[i] <= r_srl[i-1];
      end
    end
  end

  // With the output stage, the SRL is drained by refills of the output
  // register rather than directly by reads.
  if (OUT_REG != 0) begin : g_out_reg
    logic                  r_ov;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  w_load;

    assign w_load    = (r_srl_cnt != '0) && (!r_ov || w_rd_acc);
    assign w_ov_next = w_load | (r_ov & ~w_rd_acc);
    assign w_srl_pop = w_load;
    assign w_ov      = r_ov;
    assign fifo.if_dout = r_dout;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_ov   <= 1'b0;
        r_dout <= '0;
      end else begin
        r_ov <= w_ov_next;
        if (w_load) r_dout <= w_head;
      end
    end
  end else begin : g_out_comb
    assign w_ov_next    = 1'b0;
    assign w_srl_pop    = w_rd_acc;
    assign w_ov         = 1'b0;
    assign fifo.if_dout = w_head;
  end

  always_comb begin
    w_srl_cnt_next = r_srl_cnt;
    if (w_wr_acc && !w_srl_pop)      w_srl_cnt_next = r_srl_cnt + 1'b1;
    else if (!w_wr_acc && w_srl_pop) w_srl_cnt_next = r_srl_cnt - 1'b1;
    w_cnt_next = w_srl_cnt_next + {{(CW-1){1'b0}}, w_ov_next};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_srl_cnt <= '0;
      r_count   <= '0;
      r_full_n  <= 1'b1;
      r_empty_n <= 1'b0;
      r_af_n    <= !AF_ALWAYS;
    end else begin
      r_srl_cnt <= w_srl_cnt_next;
      r_count   <= w_cnt_next;
      r_full_n  <= (w_cnt_next < CAP_C);
      r_empty_n <= (OUT_REG != 0) ? w_ov_next : (w_srl_cnt_next != '0);
      r_af_n    <= !AF_ALWAYS && (w_cnt_next < AF_TH_C);
    end
  end

  assign fifo.if_full_n        = r_full_n;
  assign fifo.if_almost_full_n = r_af_n;
  assign fifo.if_empty_n       = r_empty_n;
  assign fifo.count            = r_count;

  logic w_unused;
  assign w_unused = w_ov;
endmodule

// File: tb/tb_linear_layer_srl_fifo.sv
// Three FIFO configurations driven by shared stimulus; a per-instance occupancy
// model and data scoreboard predict flags, count and head-of-queue data.
module tb_linear_layer_srl_fifo;
  logic        clk;
  logic        s_rst, s_wce, s_w, s_rce, s_r;
  logic [31:0] s_din;

  int checks   = 0;
  int failures = 0;

  // A: DEPTH 4 comb out, B: DEPTH 4 registered out, C: DEPTH 16 comb out
  int    CAPS [3] = '{4, 5, 16};
  int    AFM  [3] = '{1, 2, 2};
  bit    OREG [3] = '{1'b0, 1'b1, 1'b0};
  string NM   [3] = '{"A", "B", "C"};

  int m_srl [3];
  int m_ov  [3];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];

  linear_layer_srl_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) fa ();
  linear_layer_srl_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) fb ();
  linear_layer_srl_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) fc ();

  assign fa.if_write_ce = s_wce; assign fa.if_write = s_w; assign fa.if_din = s_din;
  assign fa.if_read_ce  = s_rce; assign fa.if_read  = s_r;
  assign fb.if_write_ce = s_wce; assign fb.if_write = s_w; assign fb.if_din = s_din;
  assign fb.if_read_ce  = s_rce; assign fb.if_read  = s_r;
  assign fc.if_write_ce = s_wce; assign fc.if_write = s_w; assign fc.if_din = s_din;
  assign fc.if_read_ce  = s_rce; assign fc.if_read  = s_r;

  linear_layer_srl_fifo #(.DATA_WIDTH(32), .DEPTH(4), .ADDR_WIDTH(2), .OUT_REG(0), .AF_MARGIN(1))
    u_dut_a (.clk(clk), .reset(s_rst), .fifo(fa));
  linear_layer_srl_fifo #(.DATA_WIDTH(32), .DEPTH(4), .ADDR_WIDTH(2), .OUT_REG(1), .AF_MARGIN(2))
    u_dut_b (.clk(clk), .reset(s_rst), .fifo(fb));
  linear_layer_srl_fifo #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4), .OUT_REG(0), .AF_MARGIN(2))
    u_dut_c (.clk(clk), .reset(s_rst), .fifo(fc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_cnt(input int i);
    case (i)
      0:       return 32'(fa.count);
      1:       return 32'(fb.count);
      default: return 32'(fc.count);
    endcase
  endfunction

  function automatic logic [31:0] get_dout(input int i);
    case (i)
      0:       return fa.if_dout;
      1:       return fb.if_dout;
      default: return fc.if_dout;
    endcase
  endfunction

  function automatic logic [2:0] get_flags(input int i);
    case (i)
      0:       return {fa.if_full_n, fa.if_almost_full_n, fa.if_empty_n};
      1:       return {fb.if_full_n, fb.if_almost_full_n, fb.if_empty_n};
      default: return {fc.if_full_n, fc.if_almost_full_n, fc.if_empty_n};
    endcase
  endfunction

  function automatic logic [31:0] sb_front(input int i);
    case (i)
      0:       return (q0.size() > 0) ? q0[0] : 32'h0;
      1:       return (q1.size() > 0) ? q1[0] : 32'h0;
      default: return (q2.size() > 0) ? q2[0] : 32'h0;
    endcase
  endfunction

  task automatic sb_push(input int i, input logic [31:0] d);
    case (i)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic sb_pop(input int i);
    case (i)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic sb_clear(input int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  function automatic int m_cnt(input int i);
    return m_srl[i] + m_ov[i];
  endfunction

  function automatic bit m_empty_n(input int i);
    return OREG[i] ? (m_ov[i] != 0) : (m_srl[i] > 0);
  endfunction

  // One clock: drive inputs, check head data, advance the model, then check state.
  task automatic step(input logic rst, input logic wce, input logic w,
                      input logic rce, input logic r, input logic [31:0] d);
    bit wr_acc, rd_acc, load;
    s_rst = rst; s_wce = wce; s_w = w; s_rce = rce; s_r = r; s_din = d;
    for (int i = 0; i < 3; i++) begin
      if (m_empty_n(i)) check({NM[i], "_head"}, get_dout(i), sb_front(i));
      wr_acc = !rst && w && wce && (m_cnt(i) < CAPS[i]);
      rd_acc = !rst && r && rce && m_empty_n(i);
      if (rst) begin
        m_srl[i] = 0;
        m_ov[i]  = 0;
        sb_clear(i);
      end else begin
        if (wr_acc) sb_push(i, d);
        if (rd_acc) sb_pop(i);
        if (OREG[i]) begin
          load     = (m_srl[i] > 0) && (m_ov[i] == 0 || rd_acc);
          m_ov[i]  = load ? 1 : (rd_acc ? 0 : m_ov[i]);
          m_srl[i] = m_srl[i] + int'(wr_acc) - int'(load);
        end else begin
          m_srl[i] = m_srl[i] + int'(wr_acc) - int'(rd_acc);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check({NM[i], "_count"}, get_cnt(i), 32'(m_cnt(i)));
      check({NM[i], "_flags"}, 32'(get_flags(i)),
            32'({m_cnt(i) < CAPS[i], m_cnt(i) < CAPS[i] - AFM[i], m_empty_n(i)}));
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 24; k++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
  endtask

  initial begin
    s_rst = 1'b1; s_wce = 1'b0; s_w = 1'b0; s_rce = 1'b0; s_r = 1'b0; s_din = '0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("rst_count_a", get_cnt(0), 32'd0);
    check("rst_flags_b", 32'(get_flags(1)), 32'b110);

    // Fill and drain
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'(k * 32'h11));
      if (k == 4) begin
        check("fill_full_n_a", 32'(fa.if_full_n), 32'd0);
        check("fill_count_a", get_cnt(0), 32'd4);
      end
    end
    check("fill_count_a_drop", get_cnt(0), 32'd4);
    check("fill_count_b", get_cnt(1), 32'd5);
    check("fill_full_n_b", 32'(fb.if_full_n), 32'd0);
    check("fill_head_a", get_dout(0), 32'h11);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    check("drain_empty_n_a", 32'(fa.if_empty_n), 32'd0);
    check("drain_count_b", get_cnt(1), 32'd0);

    // Registered output latency
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hA5);
    check("oreg_lat1_b", 32'(fb.if_empty_n), 32'd0);
    check("oreg_lat1_a", 32'(fa.if_empty_n), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    check("oreg_lat2_b", 32'(fb.if_empty_n), 32'd1);
    check("oreg_dout_b", get_dout(1), 32'hA5);
    drain();

    // Write+read at full, then at empty
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100 + 32'(k));
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1FF);
    check("full_wr_rd_a", get_cnt(0), 32'd3);
    check("full_wr_rd_b", get_cnt(1), 32'd4);
    check("full_wr_rd_fn_a", 32'(fa.if_full_n), 32'd1);
    drain();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2AA);
    check("empty_wr_rd_a", get_cnt(0), 32'd1);
    check("empty_wr_rd_b", get_cnt(1), 32'd1);
    drain();

    // Streaming at constant occupancy 2
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd1);
    for (int k = 2; k < 102; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'(k));
      check("stream_count_a", get_cnt(0), 32'd2);
    end
    check("stream_head_a", get_dout(0), 32'd100);
    drain();

    // Almost-full threshold on the 16-deep instance
    for (int k = 0; k < 13; k++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h300 + 32'(k));
    check("af_13_c", 32'(fc.if_almost_full_n), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h30D);
    check("af_14_c", 32'(fc.if_almost_full_n), 32'd0);
    check("af_14_cnt_c", get_cnt(2), 32'd14);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    check("af_back_13_c", 32'(fc.if_almost_full_n), 32'd1);
    drain();

    // Reset mid-operation
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h400 + 32'(k));
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h4FF);
    check("midrst_count_a", get_cnt(0), 32'd0);
    check("midrst_flags_a", 32'(get_flags(0)), 32'b110);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h7);
    check("midrst_dout_a", get_dout(0), 32'h7);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);

    // Random traffic with clock enables
    for (int k = 0; k < 400; k++)
      step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
